param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries (>=2, need not be a power of two).
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold (1..DEPTH-1).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wr  input  1  write request.
REQ-008 rd  input  1  read request.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 data_out  output  WIDTH  registered read data.
REQ-011 data_valid  output  1  one-cycle pulse: data_out updated by the read accepted on the previous edge.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 almost_full  output  1  count >= AF_LEVEL.
REQ-015 almost_empty  output  1  count <= AE_LEVEL.
REQ-016 count  output  CW = ceil(log2(DEPTH+1))  current occupancy.
REQ-017 overflow  output  1  sticky: a write was rejected because the FIFO was full.
REQ-018 underflow  output  1  sticky: a read was rejected because the FIFO was empty.

Function
REQ-019 Read accepted (rd_acc) iff rd && !empty.
REQ-020 Write accepted (wr_acc) iff wr && (!full || rd_acc); a full FIFO with simultaneous read accepts both.
REQ-021 Empty FIFO with wr && rd: write accepted, read rejected; no bypass, data_valid stays 0.
REQ-022 On wr_acc: mem[wr_ptr] <= data_in; wr_ptr advances, wrapping from DEPTH-1 to 0.
REQ-023 On rd_acc: data_out <= mem[rd_ptr]; rd_ptr advances, wrapping from DEPTH-1 to 0; data_valid = 1 in the next cycle.
REQ-024 Read latency is exactly one clock; data_out holds its last value when no read is accepted.
REQ-025 count next = count + wr_acc - rd_acc; simultaneous accepted read and write leave count unchanged.
REQ-026 count never exceeds DEPTH and never underflows below 0.
REQ-027 full, empty, almost_full and almost_empty are combinational decodes of the registered count; no extra latency.
REQ-028 Output order is strictly FIFO, including across pointer wrap for non-power-of-two DEPTH.

Reset
REQ-029 When rst = 1 at an edge: wr_ptr, rd_ptr, count, data_out, data_valid, overflow and underflow become 0; wr and rd are ignored in that cycle.
REQ-030 Storage array is not reset; reset mid-operation discards all contents (empty = 1 the following cycle).

Configuration
REQ-031 Macro PARAM_SYNC_FIFO_ERR_EN defined: overflow sets on wr && !wr_acc; underflow sets on rd && empty; both clear only on rst.
REQ-032 Macro PARAM_SYNC_FIFO_ERR_EN undefined: overflow and underflow ports remain present and are tied to constant 0; no error logic is synthesised.

Structure
REQ-033 Package fifo_pkg holds the default WIDTH/DEPTH constants and the clog2 width function used for pointer and count widths.
REQ-034 Storage is a sub-module fifo_ram (simple dual-port, synchronous write, registered read).
REQ-035 Pointer, count and flag logic reside in param_sync_fifo.

Verification
REQ-036 Reset, then write 16 words 0x01..0x10 (DEPTH=16) -> full=1, count=16; a 17th write is rejected, and overflow=1 when ERR_EN is defined.
REQ-037 From full, read 16 words -> data_out 0x01..0x10 in order, each one cycle after rd, data_valid pulses 16 times; then empty=1.
REQ-038 At count=16, assert wr and rd together with data_in=0xAA -> count stays 16, data_out=0x01, 0xAA is read out last.
REQ-039 DEPTH=5: write and read 12 words continuously -> correct order across two pointer wraps, count never exceeds 5.
REQ-040 Occupancy sweep: almost_full rises at count=14 and almost_empty falls at count=3 (defaults); rst asserted at count=7 -> count=0, empty=1 and data_valid=0 next cycle.

Source files
------------

// File: rtl/param_sync_fifo_pkg.sv
// fifo_pkg: shared defaults and width helper for param_sync_fifo
package fifo_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if: FIFO handshake bundle; master drives requests, slave returns data and status
interface param_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    logic                         wr;
    logic                         rd;
    logic [WIDTH-1:0]             data_in;
    logic [WIDTH-1:0]             data_out;
    logic                         data_valid;
    logic                         full;
    logic                         empty;
    logic                         almost_full;
    logic                         almost_empty;
    logic [clog2(DEPTH+1)-1:0]    count;
    logic                         overflow;
    logic                         underflow;
    modport master (
        output wr, rd, data_in,
        input  data_out, data_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  wr, rd, data_in,
        output data_out, data_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/param_sync_fifo_ram.sv
// fifo_ram: simple dual-port storage, synchronous write, registered read port that clears on rst
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;
    // storage array is deliberately left unreset
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    // read register holds its value until the next accepted read
    always_ff @(posedge clk) begin
        if (rst) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: synchronous FIFO with occupancy flags; define PARAM_SYNC_FIFO_ERR_EN for sticky overflow/underflow
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input logic                clk,
    input logic                rst,
    param_sync_fifo_if.slave   bus
);
    localparam int CW = clog2(DEPTH + 1);
    localparam int PW = clog2(DEPTH);
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic             w_full;
    logic             w_empty;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [WIDTH-1:0] w_rdata;
    assign w_full   = r_count == CW'(DEPTH);
    assign w_empty  = r_count == '0;
    assign w_rd_acc = bus.rd && !w_empty;
    assign w_wr_acc = bus.wr && (!w_full || w_rd_acc);
    // pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_acc ? (r_wr_ptr == PW'(DEPTH - 1) ? '0 : r_wr_ptr + 1'b1) : r_wr_ptr;
            r_rd_ptr <= w_rd_acc ? (r_rd_ptr == PW'(DEPTH - 1) ? '0 : r_rd_ptr + 1'b1) : r_rd_ptr;
            r_count  <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
            r_valid  <= w_rd_acc;
        end
    end
    fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_acc && !rst),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.data_in),
        .i_re    (w_rd_acc && !rst),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );
    assign bus.data_out     = w_rdata;
    assign bus.data_valid   = r_valid;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = r_count >= CW'(AF_LEVEL);
    assign bus.almost_empty = r_count <= CW'(AE_LEVEL);
`ifdef PARAM_SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;
    // sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr && !w_wr_acc) r_overflow <= 1'b1;
            if (bus.rd && w_empty) r_underflow <= 1'b1;
        end
    end
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: table vectors plus scoreboard sequences for DEPTH=16 and DEPTH=5 FIFOs
module tb_param_sync_fifo;
    localparam bit ERR =
`ifdef PARAM_SYNC_FIFO_ERR_EN
        1'b1;
`else
        1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;

    param_sync_fifo_if #(.WIDTH(8), .DEPTH(16)) a ();
    param_sync_fifo_if #(.WIDTH(8), .DEPTH(5))  b ();
    param_sync_fifo #(.WIDTH(8), .DEPTH(16)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    param_sync_fifo #(.WIDTH(8), .DEPTH(5))  dut_b (.clk(clk), .rst(rst), .bus(b.slave));

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         ma_cnt, mb_cnt, nb_valid;
    logic [7:0] ea_dout, eb_dout;
    bit         m_ovf, m_unf;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        int         cnt;
        logic       empty;
        logic       ae;
        logic       valid;
        logic [7:0] dout;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic step_a(input logic w, input logic r, input logic [7:0] d);
        bit ra, wa;
        @(negedge clk);
        a.wr = w; a.rd = r; a.data_in = d;
        ra = r && ma_cnt != 0;
        wa = w && (ma_cnt != 16 || ra);
        if (wa) qa.push_back(d);
        if (ERR && w && !wa) m_ovf = 1'b1;
        if (ERR && r && ma_cnt == 0) m_unf = 1'b1;
        ma_cnt = ma_cnt + int'(wa) - int'(ra);
        @(posedge clk); #1;
        chk("a_valid", a.data_valid, ra);
        if (a.data_valid) begin
            if (qa.size() == 0) chk("a_sb_empty", 1, 0);
            else ea_dout = qa.pop_front();
        end
        chk("a_dout", a.data_out, ea_dout);
        chk("a_count", a.count, ma_cnt);
        chk("a_full", a.full, ma_cnt == 16);
        chk("a_empty", a.empty, ma_cnt == 0);
        chk("a_af", a.almost_full, ma_cnt >= 14);
        chk("a_ae", a.almost_empty, ma_cnt <= 2);
        chk("a_ovf", a.overflow, m_ovf);
        chk("a_unf", a.underflow, m_unf);
    endtask

    task automatic step_b(input logic w, input logic r, input logic [7:0] d);
        bit ra, wa;
        @(negedge clk);
        b.wr = w; b.rd = r; b.data_in = d;
        ra = r && mb_cnt != 0;
        wa = w && (mb_cnt != 5 || ra);
        if (wa) qb.push_back(d);
        mb_cnt = mb_cnt + int'(wa) - int'(ra);
        @(posedge clk); #1;
        chk("b_valid", b.data_valid, ra);
        if (b.data_valid) begin
            nb_valid++;
            if (qb.size() == 0) chk("b_sb_empty", 1, 0);
            else eb_dout = qb.pop_front();
        end
        chk("b_dout", b.data_out, eb_dout);
        chk("b_count", b.count, mb_cnt);
        chk("b_le5", b.count <= 5, 1);
        chk("b_full", b.full, mb_cnt == 5);
    endtask

    task automatic do_reset(input logic w, input logic r);
        @(negedge clk);
        rst = 1'b1;
        a.wr = w; a.rd = r; a.data_in = 8'h5A;
        b.wr = w; b.rd = r; b.data_in = 8'h5A;
        @(posedge clk); #1;
        qa.delete(); qb.delete();
        ma_cnt = 0; mb_cnt = 0; ea_dout = '0; eb_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        chk("rst_count", a.count, 0);
        chk("rst_empty", a.empty, 1);
        chk("rst_valid", a.data_valid, 0);
        chk("rst_dout", a.data_out, 0);
        chk("rst_ovf", a.overflow, 0);
        chk("rst_unf", a.underflow, 0);
        chk("rst_b_count", b.count, 0);
        @(negedge clk);
        rst = 1'b0;
        a.wr = 1'b0; a.rd = 1'b0; b.wr = 1'b0; b.rd = 1'b0;
    endtask

    initial begin
        int vcnt;
        tbl[0] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 1'b1, 8'h55, 1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 8'h66, 2, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 8'h77, 3, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b1, 1'b1, 8'h55};
        tbl[5] = '{1'b1, 1'b1, 8'h88, 2, 1'b0, 1'b1, 1'b1, 8'h66};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1, 1'b1, 8'h77};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 1'b1, 8'h88};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 8'h88};
        a.wr = 1'b0; a.rd = 1'b0; a.data_in = '0;
        b.wr = 1'b0; b.rd = 1'b0; b.data_in = '0;
        nb_valid = 0;
        repeat (2) @(posedge clk);
        do_reset(1'b1, 1'b1);

        for (int i = 0; i < 9; i++) begin
            step_a(tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk("tbl_count", a.count, tbl[i].cnt);
            chk("tbl_empty", a.empty, tbl[i].empty);
            chk("tbl_ae", a.almost_empty, tbl[i].ae);
            chk("tbl_valid", a.data_valid, tbl[i].valid);
            chk("tbl_dout", a.data_out, tbl[i].dout);
        end
        chk("tbl_unf", a.underflow, ERR);

        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) step_a(1'b1, 1'b0, 8'(i));
        chk("fill_full", a.full, 1);
        chk("fill_count", a.count, 16);
        step_a(1'b1, 1'b0, 8'hEE);
        chk("ovf_count", a.count, 16);
        chk("ovf_flag", a.overflow, ERR);
        vcnt = 0;
        for (int i = 1; i <= 16; i++) begin
            step_a(1'b0, 1'b1, 8'h00);
            vcnt += int'(a.data_valid);
            chk("drain_order", a.data_out, i);
        end
        chk("drain_pulses", vcnt, 16);
        chk("drain_empty", a.empty, 1);
        step_a(1'b0, 1'b1, 8'h00);
        chk("unf_flag", a.underflow, ERR);

        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) step_a(1'b1, 1'b0, 8'(i));
        step_a(1'b1, 1'b1, 8'hAA);
        chk("rw_full_count", a.count, 16);
        chk("rw_full_dout", a.data_out, 8'h01);
        for (int i = 0; i < 16; i++) step_a(1'b0, 1'b1, 8'h00);
        chk("rw_full_last", a.data_out, 8'hAA);
        chk("rw_full_empty", a.empty, 1);

        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            step_a(1'b1, 1'b0, 8'(8'h30 + i));
            chk("sweep_af", a.almost_full, i >= 14);
            chk("sweep_ae", a.almost_empty, i <= 2);
        end
        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) step_a(1'b1, 1'b0, 8'(i));
        chk("pre_rst_count", a.count, 7);
        step_a(1'b0, 1'b1, 8'h00);
        do_reset(1'b1, 1'b1);
        chk("mid_rst_empty", a.empty, 1);

        for (int i = 1; i <= 5; i++) step_b(1'b1, 1'b0, 8'(i));
        chk("b_full_at5", b.full, 1);
        for (int i = 6; i <= 12; i++) step_b(1'b1, 1'b1, 8'(i));
        for (int i = 0; i < 5; i++) step_b(1'b0, 1'b1, 8'h00);
        chk("b_last", b.data_out, 12);
        chk("b_pulses", nb_valid, 12);
        chk("b_empty", b.empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
